// File: rtl/dmem_resp_if.sv
// Request/response bus between a requester and the dmem_resp memory.
// master: requester side, slave: memory side.
interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding 64-bit data memory with fixed response latency.
// Stores commit on the accept edge, loads capture the word on the accept edge,
// and the response is presented LATENCY cycles later until rsp_ready.
// Optional feature: define DMEM_RESP_ALIGN_CHECK_EN to fault accesses whose
// address is not 8-byte aligned.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request accepted, lat_cnt counting down to the response
// RESP  | response presented, held stable until rsp_ready
module dmem_resp #(
  parameter logic [63:0] BASE_ADDR = 64'h0000000080000000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input logic        clk,
  input logic        rst,
  dmem_resp_if.slave bus
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) << 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem [DEPTH];

  logic [63:0]      offset;
  logic             in_range;
  logic             misalign;
  logic             addr_ok;
  logic [IDX_W-1:0] idx;
  logic             accept;

  // Unsigned offset wraps for addresses below BASE_ADDR, so one compare
  // covers both ends of the window without computing BASE_ADDR + size.
  assign offset   = bus.req_addr - BASE_ADDR;
  assign in_range = (offset < MEM_BYTES);
  assign idx      = IDX_W'(offset >> 3);

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  assign misalign = |bus.req_addr[2:0];
`else
  assign misalign = 1'b0;
`endif

  assign addr_ok = in_range && !misalign;
  // A request seen during reset is never taken, so it cannot touch memory.
  assign accept  = bus.req_valid && (state_q == IDLE) && !rst;

  // Next-state and latency counter logic.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d   = RESP;
            lat_cnt_d = 4'd0;
          end else begin
            state_d   = WAIT;
            lat_cnt_d = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q <= 4'd1) begin
          state_d   = RESP;
          lat_cnt_d = 4'd0;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        lat_cnt_d = 4'd0;
      end
    endcase
  end

  // State, counter and captured response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= 4'd0;
      rdata_q   <= 64'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      if (accept) begin
        err_q   <= !addr_ok;
        rdata_q <= (!bus.req_we && addr_ok) ? mem[idx] : 64'd0;
      end
    end
  end

  // Byte-masked store on the accept edge; array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && addr_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.req_wmask[b]) begin
          mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
